sd_feed_ctrl: RTL

Sample-rate controller that feeds the second-order sigma-delta modulator. It accepts PCM samples over a valid/ready handshake and buffers them in a 2-entry FIFO. Each sample is clamped to the modulator's stable input range and presented on the modulator's `sd_in` for exactly OSR clocks (zero-order-hold upsampling). The block also sequences start-up, underrun and shutdown, so the modulator only ever sees silence (0) or valid held samples.

---
 rtl/sd_pkg.sv | 24 ++
 rtl/sd_fifo2.sv | 49 ++++
 rtl/sd_feed_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// Shared types and helpers for the sigma-delta feed controller.
package sd_pkg;

  localparam int unsigned SdBw = 16;

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StRun
  } sd_state_e;

  // Saturate a sign-extended sample to [-lim, +lim]; callers use BW <= 32.
  function automatic logic signed [31:0] sd_clamp(input logic signed [31:0] value,
                                                  input logic signed [31:0] lim);
    if (value > lim) begin
      return lim;
    end else if (value < -lim) begin
      return -lim;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/sd_fifo2.sv
// Two-entry synchronous FIFO with flush; entry 0 is always the head.
module sd_fifo2 #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem0_q, mem1_q;
  logic [1:0]       count_q;
  logic             push_ok, pop_ok;

  always_comb begin
    push_ok = push_i && (count_q != 2'd2);
    pop_ok  = pop_i && (count_q != 2'd0);
    rdata_o = mem0_q;
    count_o = count_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      count_q <= 2'd0;
    end else if (push_ok && !pop_ok) begin
      count_q <= count_q + 2'd1;
    end else if (pop_ok && !push_ok) begin
      count_q <= count_q - 2'd1;
    end
  end

  // Push together with pop implies count was 1, so the new word becomes the head.
  always_ff @(posedge clk_i) begin
    if (pop_ok) begin
      mem0_q <= push_ok ? wdata_i : mem1_q;
    end else if (push_ok) begin
      if (count_q == 2'd0) begin
        mem0_q <= wdata_i;
      end else begin
        mem1_q <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/sd_feed_ctrl.sv
// Buffers PCM samples and holds each clamped sample on sd_in for OSR clocks,
// sequencing start-up, underrun and shutdown so the modulator sees only silence or data.
module sd_feed_ctrl
  import sd_pkg::*;
#(
  parameter int unsigned BW  = SdBw,
  parameter int unsigned OSR = 64,
  parameter int unsigned LIM = 24576
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic signed [BW-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic signed [BW-1:0] sd_in,
  output logic                 strobe,
  output logic                 underrun,
  output logic                 clip,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(OSR);

  if (BW > 32 || BW < 2) begin : g_bad_bw
    $error("sd_feed_ctrl: BW must be in 2..32");
  end
  if (OSR < 2) begin : g_bad_osr
    $error("sd_feed_ctrl: OSR must be at least 2");
  end
  if (longint'(LIM) > ((longint'(1) << (BW - 1)) - 1)) begin : g_bad_lim
    $error("sd_feed_ctrl: LIM exceeds the signed BW range");
  end

  sd_state_e             state_q;
  logic [CntW-1:0]       cnt_q;
  logic signed [BW-1:0]  sd_in_q;
  logic                  strobe_q, underrun_q, clip_q;

  logic [1:0]            fifo_count;
  logic [BW-1:0]         fifo_rdata;
  logic                  fifo_push, fifo_pop, fifo_flush;
  logic                  at_boundary;
  logic signed [31:0]    head_ext, clamped;
  logic signed [BW-1:0]  load_val;
  logic                  load_clip;

  always_comb begin
    at_boundary = (state_q == StRun) && (cnt_q == CntW'(OSR - 1));
    s_ready     = (state_q != StIdle) && (fifo_count < 2'd2);
    busy        = (state_q == StPrime) || (state_q == StRun);
    fifo_push   = s_valid && s_ready;
    fifo_pop    = ((state_q == StPrime) && en && (fifo_count == 2'd2)) ||
                  (at_boundary && en && (fifo_count != 2'd0));
    // Shutdown flush wins over a same-cycle push so IDLE always starts empty.
    fifo_flush  = (state_q == StIdle) || (at_boundary && !en);
    head_ext    = 32'(signed'(fifo_rdata));
    clamped     = sd_clamp(head_ext, signed'(32'(LIM)));
    load_val    = clamped[BW-1:0];
    load_clip   = (clamped != head_ext);
  end

  sd_fifo2 #(
    .Width(BW)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .flush_i(fifo_flush),
    .push_i (fifo_push),
    .pop_i  (fifo_pop),
    .wdata_i(s_data),
    .rdata_o(fifo_rdata),
    .count_o(fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sd_in_q    <= '0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
      clip_q     <= 1'b0;
    end else begin
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
      clip_q     <= 1'b0;
      case (state_q)
        StIdle: begin
          sd_in_q <= '0;
          cnt_q   <= '0;
          if (en) state_q <= StPrime;
        end
        StPrime: begin
          if (!en) begin
            state_q <= StIdle;
          end else if (fifo_count == 2'd2) begin
            state_q  <= StRun;
            sd_in_q  <= load_val;
            clip_q   <= load_clip;
            strobe_q <= 1'b1;
            cnt_q    <= '0;
          end
        end
        StRun: begin
          if (at_boundary) begin
            cnt_q <= '0;
            if (!en) begin
              state_q <= StIdle;
              sd_in_q <= '0;
            end else if (fifo_count != 2'd0) begin
              sd_in_q  <= load_val;
              clip_q   <= load_clip;
              strobe_q <= 1'b1;
            end else begin
              state_q    <= StPrime;
              sd_in_q    <= '0;
              underrun_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    sd_in    = sd_in_q;
    strobe   = strobe_q;
    underrun = underrun_q;
    clip     = clip_q;
  end

endmodule
